// File: rtl/mem_arbiter_if.sv
// Requester, memory and status signals for mem_arbiter.
// lock0/lock1 exist only when MEM_ARB_LOCK_EN is defined.
`timescale 1ns/1ps
interface mem_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic             we0;
    logic [WIDTH-1:0] addr0;
    logic [WIDTH-1:0] wdata0;
    logic             ack0;
    logic [WIDTH-1:0] rdata0;

    logic             req1;
    logic             we1;
    logic [WIDTH-1:0] addr1;
    logic [WIDTH-1:0] wdata1;
    logic             ack1;
    logic [WIDTH-1:0] rdata1;

    logic             mem_we;
    logic [WIDTH-1:0] mem_a;
    logic [WIDTH-1:0] mem_wd;
    logic [WIDTH-1:0] mem_rd;

    logic             busy;
    logic             owner;
`ifdef MEM_ARB_LOCK_EN
    logic             lock0;
    logic             lock1;
`endif

    modport slave (
`ifdef MEM_ARB_LOCK_EN
        input  lock0, lock1,
`endif
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rd,
        output ack0, rdata0, ack1, rdata1,
        output mem_we, mem_a, mem_wd,
        output busy, owner
    );

    modport master (
`ifdef MEM_ARB_LOCK_EN
        output lock0, lock1,
`endif
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rd,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_we, mem_a, mem_wd,
        input  busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a single-port memory.
// Define MEM_ARB_LOCK_EN to add lock0/lock1 owner locking for read-modify-write.
//
// state  | meaning
// IDLE   | waiting for a request; grant latched into owner on exit
// ACCESS | memory driven from owner's inputs; read data captured on exit
// DONE   | one-cycle ack to owner; requests ignored
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int WIDTH      = 8,
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t           state;
    logic             owner;
    logic             last_owner;
    logic             ack0;
    logic             ack1;
    logic [WIDTH-1:0] rdata0;
    logic [WIDTH-1:0] rdata1;
`ifdef MEM_ARB_LOCK_EN
    logic             locked;
`endif

    logic             sel_we;
    logic [WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    logic             grant_valid;
    logic             grant_idx;

    always_comb begin
        sel_we    = owner ? bus.we1    : bus.we0;
        sel_addr  = owner ? bus.addr1  : bus.addr0;
        sel_wdata = owner ? bus.wdata1 : bus.wdata0;
    end

    // Contested grant goes to whoever was not served last.
    always_comb begin
        grant_valid = bus.req0 | bus.req1;
        grant_idx   = bus.req1 & ~bus.req0;
        if (bus.req0 && bus.req1) begin
            grant_idx = ~last_owner;
        end
`ifdef MEM_ARB_LOCK_EN
        if (locked) begin
            grant_valid = owner ? bus.req1 : bus.req0;
            grant_idx   = owner;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= FIRST_PRIO;
            last_owner <= ~FIRST_PRIO;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
`ifdef MEM_ARB_LOCK_EN
            locked     <= 1'b0;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner <= grant_idx;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (owner) begin
                        rdata1 <= bus.mem_rd;
                        ack1   <= 1'b1;
                    end else begin
                        rdata0 <= bus.mem_rd;
                        ack0   <= 1'b1;
                    end
                    last_owner <= owner;
                    state      <= DONE;
                end
                DONE: begin
`ifdef MEM_ARB_LOCK_EN
                    locked <= owner ? bus.lock1 : bus.lock0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // mem_we decodes state directly so an async reset drops it at once.
    assign bus.mem_we = (state == ACCESS) & sel_we;
    assign bus.mem_a  = sel_addr;
    assign bus.mem_wd = sel_wdata;
    assign bus.ack0   = ack0;
    assign bus.ack1   = ack1;
    assign bus.rdata0 = rdata0;
    assign bus.rdata1 = rdata1;
    assign bus.busy   = (state != IDLE);
    assign bus.owner  = owner;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural single-port memory.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         init_mem;
    logic [W-1:0] mem_arr   [256];
    logic [W-1:0] model_mem [256];
    logic [W-1:0] exp_q0 [$];
    logic [W-1:0] exp_q1 [$];
    bit           ack_log [$];
    bit           log_en;
    int           n_tests;
    int           n_fail;
    int           we_cnt;

    mem_arbiter_if #(.WIDTH(W)) bus ();

    mem_arbiter #(.WIDTH(W), .FIRST_PRIO(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] preload(input int i);
        logic [W-1:0] v;
        v = W'(i);
        case (i)
            1:       return 8'h11;
            2:       return 8'h22;
            7:       return 8'h33;
            default: return (i >= 16 && i < 32) ? (v ^ 8'h5A) : 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= preload(i);
        end else if (bus.mem_we) begin
            mem_arr[bus.mem_a] <= bus.mem_wd;
        end
    end
    assign bus.mem_rd = mem_arr[bus.mem_a];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_we) we_cnt++;
        if (bus.ack0 || bus.ack1) begin
            chk("ack_onehot", 32'(bus.ack0 & bus.ack1), 32'd0);
            chk("ack_owner", 32'(bus.owner), 32'(bus.ack1));
            chk("busy_in_done", 32'(bus.busy), 32'd1);
            if (log_en) ack_log.push_back(bus.ack1);
            if (bus.ack0) begin
                chk("ack0_expected", 32'(exp_q0.size() != 0), 32'd1);
                if (exp_q0.size() != 0) chk("rdata0", 32'(bus.rdata0), 32'(exp_q0.pop_front()));
            end
            if (bus.ack1) begin
                chk("ack1_expected", 32'(exp_q1.size() != 0), 32'd1);
                if (exp_q1.size() != 0) chk("rdata1", 32'(bus.rdata1), 32'(exp_q1.pop_front()));
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that samples ack.
    task automatic txn(input bit idx, input bit we, input logic [W-1:0] a,
                       input logic [W-1:0] d, input bit hold, output int lat);
        logic [W-1:0] e;
        bit got;
        e = model_mem[a];
        if (we) model_mem[a] = d;
        if (idx) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
            exp_q1.push_back(e);
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
            exp_q0.push_back(e);
        end
        lat = -1;
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (idx ? bus.ack1 : bus.ack0) begin
                lat = n;
                got = 1'b1;
                break;
            end
        end
        chk(idx ? "ack1_timeout" : "ack0_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) begin
            if (idx) begin bus.req1 = 1'b0; bus.we1 = 1'b0; end
            else     begin bus.req0 = 1'b0; bus.we0 = 1'b0; end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int la, lb, w0, ones;
        n_tests = 0; n_fail = 0; we_cnt = 0; log_en = 1'b0;
        for (int i = 0; i < 256; i++) model_mem[i] = preload(i);
        rst = 1'b1; init_mem = 1'b1;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
`ifdef MEM_ARB_LOCK_EN
        bus.lock0 = 1'b0; bus.lock1 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        init_mem = 1'b0;
        chk("rst_ack0",   32'(bus.ack0),   32'd0);
        chk("rst_ack1",   32'(bus.ack1),   32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_rdata0", 32'(bus.rdata0), 32'd0);
        chk("rst_rdata1", 32'(bus.rdata1), 32'd0);
        chk("rst_owner",  32'(bus.owner),  32'd0);
        chk("rst_busy",   32'(bus.busy),   32'd0);
        rst = 1'b0;

        // contention straight out of reset: requester 0 favoured
        fork
            txn(1'b0, 1'b0, 8'd1, 8'h00, 1'b0, la);
            txn(1'b1, 1'b0, 8'd2, 8'h00, 1'b0, lb);
        join
        chk("cont_lat0", 32'(la), 32'd2);
        chk("cont_lat1", 32'(lb), 32'd5);
        chk("cont_rd0",  32'(bus.rdata0), 32'h11);
        chk("cont_rd1",  32'(bus.rdata1), 32'h22);

        // single write then read on requester 1
        w0 = we_cnt;
        txn(1'b1, 1'b1, 8'd5, 8'hA5, 1'b0, la);
        chk("wr_lat", 32'(la), 32'd2);
        chk("wr_we_cycles", 32'(we_cnt - w0), 32'd1);
        w0 = we_cnt;
        txn(1'b1, 1'b0, 8'd5, 8'h00, 1'b0, la);
        chk("rd_lat", 32'(la), 32'd2);
        chk("rd_we_cycles", 32'(we_cnt - w0), 32'd0);
        chk("rd_a5", 32'(bus.rdata1), 32'hA5);

        // read-before-write on requester 0
        txn(1'b0, 1'b1, 8'd7, 8'h44, 1'b0, la);
        chk("rbw_old", 32'(bus.rdata0), 32'h33);
        txn(1'b0, 1'b0, 8'd7, 8'h00, 1'b0, la);
        chk("rbw_new", 32'(bus.rdata0), 32'h44);

        // fairness under continuous contention
        ack_log.delete();
        log_en = 1'b1;
        fork
            for (int i = 0; i < 5; i++) txn(1'b0, 1'b0, W'(16 + i), 8'h00, i < 4, la);
            for (int j = 0; j < 5; j++) txn(1'b1, 1'b0, W'(24 + j), 8'h00, j < 4, lb);
        join
        log_en = 1'b0;
        chk("fair_count", 32'(ack_log.size()), 32'd10);
        if (ack_log.size() == 10) begin
            ones = 0;
            for (int i = 0; i < 10; i++) ones += int'(ack_log[i]);
            chk("fair_share", 32'(ones), 32'd5);
            for (int i = 1; i < 10; i++) chk("fair_alternate", 32'(ack_log[i]), 32'(!ack_log[i-1]));
        end

        // reset during the ACCESS cycle of a write
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'd9; bus.wdata0 = 8'h55;
        @(posedge clk);
        #1;
        chk("abort_we_in_access", 32'(bus.mem_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_we_drop", 32'(bus.mem_we), 32'd0);
        chk("abort_busy",    32'(bus.busy),   32'd0);
        bus.req0 = 1'b0; bus.we0 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_rdata0", 32'(bus.rdata0), 32'd0);
        chk("abort_owner",  32'(bus.owner),  32'd0);
        txn(1'b0, 1'b0, 8'd9, 8'h00, 1'b0, la);
        chk("abort_rd9", 32'(bus.rdata0), 32'h00);

`ifdef MEM_ARB_LOCK_EN
        // locked read-modify-write burst on requester 1 while requester 0 waits
        ack_log.delete();
        log_en = 1'b1;
        fork
            begin
                bus.lock1 = 1'b1;
                txn(1'b1, 1'b1, 8'd40, 8'hC1, 1'b1, la);
                txn(1'b1, 1'b1, 8'd41, 8'hC2, 1'b1, la);
                bus.lock1 = 1'b0;
                txn(1'b1, 1'b1, 8'd42, 8'hC3, 1'b0, la);
            end
            begin
                @(posedge clk);
                #1;
                txn(1'b0, 1'b0, 8'd16, 8'h00, 1'b0, lb);
            end
        join
        log_en = 1'b0;
        chk("lock_count", 32'(ack_log.size()), 32'd4);
        if (ack_log.size() == 4) begin
            chk("lock_ack_a", 32'(ack_log[0]), 32'd1);
            chk("lock_ack_b", 32'(ack_log[1]), 32'd1);
            chk("lock_ack_c", 32'(ack_log[2]), 32'd1);
            chk("lock_release", 32'(ack_log[3]), 32'd0);
        end
`endif

        repeat (3) @(posedge clk);
        chk("q0_drained", 32'(exp_q0.size()), 32'd0);
        chk("q1_drained", 32'(exp_q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
